// File: rtl/pcm_fetch.sv
// PCM sample fetcher: round-robin ROM reads for NCH channels, each with a
// 16.8 fixed-point position, step, end marker and optional loop point.
module pcm_fetch #(
   parameter int NCH      = 8,
   parameter int ROM_WAIT = 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   CPU_WE,
   input  logic [$clog2(NCH)+2:0] CPU_ADDR,
   input  logic [7:0]             CPU_DIN,
   output logic [15:0]            ROM_ADDR,
   output logic                   ROM_nOE,
   input  logic [7:0]             ROM_DATA,
   output logic [7:0]             SAMPLE,
   output logic [$clog2(NCH)-1:0] SAMPLE_CH,
   output logic                   SAMPLE_VALID
);
   localparam int         CHW       = $clog2(NCH);
   localparam logic [1:0] WAIT_LAST = 2'(ROM_WAIT - 1);

   typedef enum logic [1:0] {S_ADDR, S_READ, S_LATCH, S_UPDATE} state_t;
   state_t r_state, w_state_nxt;

   logic [CHW-1:0] r_ch;
   logic [1:0]     r_wait;
   logic           r_slot_en;
   logic [15:0]    r_addr_hold;

   logic [7:0]  r_start_lo [NCH];
   logic [7:0]  r_start_hi [NCH];
   logic [7:0]  r_loop_lo  [NCH];
   logic [7:0]  r_loop_hi  [NCH];
   logic [7:0]  r_end_hi   [NCH];
   logic [7:0]  r_step     [NCH];
   logic [1:0]  r_ctrl     [NCH];
   logic [23:0] r_pos      [NCH];

   logic [CHW-1:0] w_wr_ch;
   logic [2:0]     w_wr_reg;
   logic           w_ctrl_wr;
   logic [23:0]    w_pos_cur;
   logic [23:0]    w_pos_inc;
   logic           w_end_hit;
   logic           w_advance;

   assign w_wr_ch   = CPU_ADDR[CHW+2:3];
   assign w_wr_reg  = CPU_ADDR[2:0];
   assign w_ctrl_wr = CPU_WE && (w_wr_reg == 3'd6);
   assign w_pos_cur = r_pos[r_ch];
   assign w_pos_inc = w_pos_cur + {12'b0, r_step[r_ch], 4'b0};
   assign w_end_hit = (w_pos_inc[23:16] == r_end_hi[r_ch]);
   // Enable is snapshotted at S_ADDR; a CPU disable mid-slot also blocks the advance.
   assign w_advance = (r_state == S_UPDATE) && r_slot_en && r_ctrl[r_ch][0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NCH; i++) begin
            r_start_lo[i] <= '0;
            r_start_hi[i] <= '0;
            r_loop_lo[i]  <= '0;
            r_loop_hi[i]  <= '0;
            r_end_hi[i]   <= '0;
            r_step[i]     <= '0;
            r_ctrl[i]     <= '0;
            r_pos[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (CPU_WE && w_wr_ch == CHW'(i)) begin
               case (w_wr_reg)
                  3'd0: r_start_lo[i] <= CPU_DIN;
                  3'd1: r_start_hi[i] <= CPU_DIN;
                  3'd2: r_loop_lo[i]  <= CPU_DIN;
                  3'd3: r_loop_hi[i]  <= CPU_DIN;
                  3'd4: r_end_hi[i]   <= CPU_DIN;
                  3'd5: r_step[i]     <= CPU_DIN;
                  3'd6: begin
                     r_ctrl[i] <= CPU_DIN[1:0];
                     if (!r_ctrl[i][0] && CPU_DIN[0])
                        r_pos[i] <= {r_start_hi[i], r_start_lo[i], 8'h00};
                  end
                  default: ;
               endcase
            end
            // A CTRL write landing on this channel's update cycle overrides the sequencer.
            if (w_advance && r_ch == CHW'(i) && !(w_ctrl_wr && w_wr_ch == CHW'(i))) begin
               if (w_end_hit) begin
                  if (r_ctrl[i][1])
                     r_pos[i] <= {r_loop_hi[i], r_loop_lo[i], 8'h00};
                  else
                     r_ctrl[i][0] <= 1'b0;
               end else begin
                  r_pos[i] <= w_pos_inc;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         r_state <= S_ADDR;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ROM_nOE     = 1'b1;
      ROM_ADDR    = r_addr_hold;
      case (r_state)
         S_ADDR: begin
            ROM_ADDR    = w_pos_cur[23:8];
            w_state_nxt = S_READ;
         end
         S_READ: begin
            ROM_nOE = !r_slot_en;
            if (r_wait == WAIT_LAST)
               w_state_nxt = S_LATCH;
         end
         S_LATCH: begin
            ROM_nOE     = !r_slot_en;
            w_state_nxt = S_UPDATE;
         end
         default: w_state_nxt = S_ADDR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ch         <= '0;
         r_wait       <= '0;
         r_slot_en    <= 1'b0;
         r_addr_hold  <= '0;
         SAMPLE       <= '0;
         SAMPLE_CH    <= '0;
         SAMPLE_VALID <= 1'b0;
      end else begin
         SAMPLE_VALID <= 1'b0;
         case (r_state)
            S_ADDR: begin
               r_addr_hold <= w_pos_cur[23:8];
               r_slot_en   <= r_ctrl[r_ch][0];
               r_wait      <= '0;
            end
            S_READ: r_wait <= r_wait + 2'd1;
            S_LATCH: begin
               if (r_slot_en) begin
                  SAMPLE       <= ROM_DATA;
                  SAMPLE_CH    <= r_ch;
                  SAMPLE_VALID <= 1'b1;
               end
            end
            default: r_ch <= r_ch + CHW'(1);
         endcase
      end
   end
endmodule

// File: tb/tb_pcm_fetch.sv
// Bench for pcm_fetch: slot-timeline model checked every cycle, plus directed
// scenarios with hand-computed fetch addresses and sample values.
module tb_pcm_fetch;
   localparam int NCH  = 8;
   localparam int W    = 1;
   localparam int SLOT = W + 3;
   localparam int CHW  = 3;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic           CPU_WE = 1'b0;
   logic [CHW+2:0] CPU_ADDR = '0;
   logic [7:0]     CPU_DIN = '0;
   logic [15:0]    ROM_ADDR;
   logic           ROM_nOE;
   logic [7:0]     ROM_DATA;
   logic [7:0]     SAMPLE;
   logic [CHW-1:0] SAMPLE_CH;
   logic           SAMPLE_VALID;

   logic [7:0] rom [0:65535];
   assign ROM_DATA = rom[ROM_ADDR];

   always #5 CLK = ~CLK;

   pcm_fetch #(.NCH(NCH), .ROM_WAIT(W)) dut (
      .CLK(CLK), .RESET(RESET), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
      .CPU_DIN(CPU_DIN), .ROM_ADDR(ROM_ADDR), .ROM_nOE(ROM_nOE),
      .ROM_DATA(ROM_DATA), .SAMPLE(SAMPLE), .SAMPLE_CH(SAMPLE_CH),
      .SAMPLE_VALID(SAMPLE_VALID)
   );

   int checks = 0, failures = 0, nprint = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (nprint < 30) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
         nprint++;
      end
   endtask

   // Model: channel registers plus a timeline where cycle t since reset is
   // phase t%SLOT of channel (t/SLOT)%NCH.
   logic [7:0]     m_sl [NCH], m_sh [NCH], m_ll [NCH], m_lh [NCH], m_eh [NCH], m_st [NCH];
   bit             m_en [NCH], m_lp [NCH];
   logic [23:0]    m_pos [NCH];
   int             m_t = 0;
   logic [15:0]    m_snap_addr = '0;
   bit             m_snap_en = 0;
   logic [7:0]     m_sample = '0;
   logic [CHW-1:0] m_sch = '0;
   bit             started = 0;
   longint         cyc = 0;
   int             mp, mc, wc, wr;
   bit             ctrl_hit;
   logic [23:0]    np;

   initial forever begin
      @(posedge CLK);
      cyc++;
      started = 1;
      if (RESET) begin
         for (int i = 0; i < NCH; i++) begin
            m_sl[i] = 0; m_sh[i] = 0; m_ll[i] = 0; m_lh[i] = 0; m_eh[i] = 0; m_st[i] = 0;
            m_en[i] = 0; m_lp[i] = 0; m_pos[i] = 0;
         end
         m_t = 0; m_snap_addr = 0; m_snap_en = 0; m_sample = 0; m_sch = 0;
      end else begin
         mp = m_t % SLOT;
         mc = (m_t / SLOT) % NCH;
         wc = int'(CPU_ADDR[CHW+2:3]);
         wr = int'(CPU_ADDR[2:0]);
         ctrl_hit = CPU_WE && wr == 6 && wc == mc;
         if (mp == 0) begin
            m_snap_addr = m_pos[mc][23:8];
            m_snap_en   = m_en[mc];
         end
         if (mp == W + 1 && m_snap_en) begin
            m_sample = rom[m_snap_addr];
            m_sch    = CHW'(mc);
         end
         if (mp == W + 2 && m_snap_en && m_en[mc] && !ctrl_hit) begin
            np = m_pos[mc] + (24'(m_st[mc]) << 4);
            if (np[23:16] == m_eh[mc]) begin
               if (m_lp[mc]) m_pos[mc] = {m_lh[mc], m_ll[mc], 8'h00};
               else          m_en[mc] = 0;
            end else begin
               m_pos[mc] = np;
            end
         end
         if (CPU_WE) begin
            case (wr)
               0: m_sl[wc] = CPU_DIN;
               1: m_sh[wc] = CPU_DIN;
               2: m_ll[wc] = CPU_DIN;
               3: m_lh[wc] = CPU_DIN;
               4: m_eh[wc] = CPU_DIN;
               5: m_st[wc] = CPU_DIN;
               6: begin
                  if (!m_en[wc] && CPU_DIN[0]) m_pos[wc] = {m_sh[wc], m_sl[wc], 8'h00};
                  m_en[wc] = CPU_DIN[0];
                  m_lp[wc] = CPU_DIN[1];
               end
               default: ;
            endcase
         end
         m_t++;
      end
   end

   int          cp, cc;
   logic [15:0] e_addr;
   bit          e_noe, e_vld;

   initial forever begin
      @(negedge CLK);
      if (started) begin
         cp     = m_t % SLOT;
         cc     = (m_t / SLOT) % NCH;
         e_noe  = !(m_snap_en && cp >= 1 && cp <= W + 1);
         e_addr = (cp == 0) ? m_pos[cc][23:8] : m_snap_addr;
         e_vld  = (cp == W + 2) && m_snap_en;
         chk("cyc_rom_addr", 32'(ROM_ADDR), 32'(e_addr));
         chk("cyc_rom_noe", 32'(ROM_nOE), 32'(e_noe));
         chk("cyc_valid", 32'(SAMPLE_VALID), 32'(e_vld));
         chk("cyc_sample", 32'(SAMPLE), 32'(m_sample));
         chk("cyc_sample_ch", 32'(SAMPLE_CH), 32'(m_sch));
      end
   end

   logic [15:0]    fetch_q [$];
   logic [7:0]     smp_q [$];
   logic [CHW-1:0] sch_q [$];
   longint         stamp_q [$];
   bit             prev_noe = 1;

   initial forever begin
      @(negedge CLK);
      if (ROM_nOE === 1'b0 && prev_noe) fetch_q.push_back(ROM_ADDR);
      prev_noe = (ROM_nOE !== 1'b0);
      if (SAMPLE_VALID === 1'b1) begin
         smp_q.push_back(SAMPLE);
         sch_q.push_back(SAMPLE_CH);
         stamp_q.push_back(cyc);
      end
   end

   task automatic cpu_wr(input int ch, input int r, input logic [7:0] d);
      CPU_WE   = 1'b1;
      CPU_ADDR = {CHW'(ch), 3'(r)};
      CPU_DIN  = d;
      @(negedge CLK);
      CPU_WE   = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      fetch_q.delete(); smp_q.delete(); sch_q.delete(); stamp_q.delete();
      RESET = 1'b0;
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s timeout actual=expired required=event", nm);
   endtask

   task automatic wait_fetch(input int n);
      int k = 0;
      while (fetch_q.size() < n && k < 400) begin @(negedge CLK); k++; end
      if (fetch_q.size() < n) timeout("wait_fetch");
   endtask

   task automatic wait_pulse(input int n);
      int k = 0;
      while (smp_q.size() < n && k < 400) begin @(negedge CLK); k++; end
      if (smp_q.size() < n) timeout("wait_pulse");
   endtask

   task automatic wait_phase(input int ch, input int ph);
      int k = 0;
      while (!(m_t % SLOT == ph && (m_t / SLOT) % NCH == ch) && k < 200) begin
         @(negedge CLK); k++;
      end
      if (k >= 200) timeout("wait_phase");
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rom_addr"}, 32'(ROM_ADDR), 32'h0);
      chk({tag, "_rom_noe"}, 32'(ROM_nOE), 32'h1);
      chk({tag, "_sample"}, 32'(SAMPLE), 32'h0);
      chk({tag, "_sample_ch"}, 32'(SAMPLE_CH), 32'h0);
      chk({tag, "_valid"}, 32'(SAMPLE_VALID), 32'h0);
   endtask

   initial begin
      int nlow, nv, n0;
      for (int i = 0; i < 65536; i++) rom[i] = 8'(i) ^ 8'(i >> 8);
      rom[16'h1000] = 8'hA0; rom[16'h1001] = 8'hA1; rom[16'h1002] = 8'hA2;
      rom[16'h12FE] = 8'h11; rom[16'h12FF] = 8'h22;
      rom[16'h1200] = 8'h33; rom[16'h1201] = 8'h44;

      @(negedge CLK);
      @(negedge CLK);
      chk_reset_outs("init_rst");
      RESET = 1'b0;

      // Idle: nothing enabled, ROM never read.
      nlow = 0; nv = 0;
      repeat (200) begin
         @(negedge CLK);
         if (ROM_nOE !== 1'b1) nlow++;
         if (SAMPLE_VALID !== 1'b0) nv++;
      end
      chk("idle_noe_low_cycles", 32'(nlow), 0);
      chk("idle_pulses", 32'(nv), 0);

      // Channel 2 linear playback, one pulse per full rotation.
      cpu_wr(2, 0, 8'h00); cpu_wr(2, 1, 8'h10); cpu_wr(2, 5, 8'h10);
      cpu_wr(2, 4, 8'hFF); cpu_wr(2, 6, 8'h01);
      wait_pulse(3);
      if (smp_q.size() >= 3) begin
         chk("ch2_s0", 32'(smp_q[0]), 32'hA0);
         chk("ch2_s1", 32'(smp_q[1]), 32'hA1);
         chk("ch2_s2", 32'(smp_q[2]), 32'hA2);
         chk("ch2_ch0", 32'(sch_q[0]), 2);
         chk("ch2_ch2", 32'(sch_q[2]), 2);
         chk("ch2_gap1", 32'(stamp_q[1] - stamp_q[0]), 32);
         chk("ch2_gap2", 32'(stamp_q[2] - stamp_q[1]), 32);
      end

      // Channel 0 looping across the end marker.
      do_reset();
      cpu_wr(0, 0, 8'hFE); cpu_wr(0, 1, 8'h12); cpu_wr(0, 5, 8'h10); cpu_wr(0, 4, 8'h13);
      cpu_wr(0, 2, 8'h00); cpu_wr(0, 3, 8'h12); cpu_wr(0, 6, 8'h03);
      wait_fetch(4);
      wait_pulse(4);
      if (fetch_q.size() >= 4) begin
         chk("loop_a0", 32'(fetch_q[0]), 32'h12FE);
         chk("loop_a1", 32'(fetch_q[1]), 32'h12FF);
         chk("loop_a2", 32'(fetch_q[2]), 32'h1200);
         chk("loop_a3", 32'(fetch_q[3]), 32'h1201);
      end
      if (smp_q.size() >= 4) chk("loop_s3", 32'(smp_q[3]), 32'h44);

      // Same without LOOP: two samples then the channel stops.
      do_reset();
      cpu_wr(0, 0, 8'hFE); cpu_wr(0, 1, 8'h12); cpu_wr(0, 5, 8'h10); cpu_wr(0, 4, 8'h13);
      cpu_wr(0, 2, 8'h00); cpu_wr(0, 3, 8'h12); cpu_wr(0, 6, 8'h01);
      repeat (200) @(negedge CLK);
      chk("noloop_fetches", 32'(fetch_q.size()), 2);
      chk("noloop_pulses", 32'(smp_q.size()), 2);
      if (smp_q.size() >= 2) begin
         chk("noloop_s0", 32'(smp_q[0]), 32'h11);
         chk("noloop_s1", 32'(smp_q[1]), 32'h22);
      end

      // Half step: each byte fetched twice.
      do_reset();
      cpu_wr(1, 0, 8'h00); cpu_wr(1, 1, 8'h20); cpu_wr(1, 5, 8'h08);
      cpu_wr(1, 4, 8'hFF); cpu_wr(1, 6, 8'h01);
      wait_fetch(4);
      if (fetch_q.size() >= 4) begin
         chk("half_a0", 32'(fetch_q[0]), 32'h2000);
         chk("half_a1", 32'(fetch_q[1]), 32'h2000);
         chk("half_a2", 32'(fetch_q[2]), 32'h2001);
         chk("half_a3", 32'(fetch_q[3]), 32'h2001);
      end

      // CTRL write on the update cycle discards that slot's advance.
      do_reset();
      cpu_wr(0, 0, 8'h00); cpu_wr(0, 1, 8'h50); cpu_wr(0, 5, 8'h10);
      cpu_wr(0, 4, 8'hFF); cpu_wr(0, 6, 8'h01);
      wait_fetch(1);
      wait_phase(0, W + 2);
      cpu_wr(0, 6, 8'h01);
      wait_fetch(3);
      if (fetch_q.size() >= 3) begin
         chk("race_a0", 32'(fetch_q[0]), 32'h5000);
         chk("race_a1", 32'(fetch_q[1]), 32'h5000);
         chk("race_a2", 32'(fetch_q[2]), 32'h5001);
      end

      // Reset during channel 3's read phase.
      do_reset();
      cpu_wr(3, 0, 8'h00); cpu_wr(3, 1, 8'h30); cpu_wr(3, 5, 8'h10);
      cpu_wr(3, 4, 8'hFF); cpu_wr(3, 6, 8'h01);
      wait_pulse(1);
      wait_phase(3, 1);
      n0 = smp_q.size();
      RESET = 1'b1;
      @(negedge CLK);
      chk_reset_outs("mid_rst");
      RESET = 1'b0;
      repeat (8) @(negedge CLK);
      chk("mid_rst_no_pulse", 32'(smp_q.size()), 32'(n0));
      cpu_wr(0, 0, 8'h00); cpu_wr(0, 1, 8'h40); cpu_wr(0, 5, 8'h10);
      cpu_wr(0, 4, 8'hFF); cpu_wr(0, 6, 8'h01);
      wait_pulse(n0 + 1);
      if (smp_q.size() > n0) begin
         chk("post_rst_ch", 32'(sch_q[n0]), 0);
         chk("post_rst_s", 32'(smp_q[n0]), 32'h40);
      end

      repeat (4) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcm_fetch.md
PCM_FETCH -- requirements
Module: pcm_fetch

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning number of PCM channels; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter ROM_WAIT, default 1, meaning the number of cycles ROM_nOE is low before ROM_DATA is sampled; legal range is 1..4.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port CPU_WE, input, 1 bit: register write strobe, sampled each cycle.
REQ-006 SHALL have port CPU_ADDR, input, log2(NCH)+3 bits: {channel, reg[2:0]}.
REQ-007 SHALL have port CPU_DIN, input, 8 bits: register write data.
REQ-008 SHALL have port ROM_ADDR, output, 16 bits: sample ROM byte address.
REQ-009 SHALL have port ROM_nOE, output, 1 bit: ROM output enable, active low.
REQ-010 SHALL have port ROM_DATA, input, 8 bits: ROM read data.
REQ-011 SHALL have port SAMPLE, output, 8 bits: last fetched sample byte.
REQ-012 SHALL have port SAMPLE_CH, output, log2(NCH) bits: channel that owns SAMPLE.
REQ-013 SHALL have port SAMPLE_VALID, output, 1 bit: one-cycle pulse when SAMPLE/SAMPLE_CH update.

Function
REQ-014 Per-channel registers SHALL be: reg0 START_LO, reg1 START_HI, reg2 LOOP_LO, reg3 LOOP_HI, reg4 END_HI, reg5 STEP (unsigned 4.4), reg6 CTRL (bit0 EN, bit1 LOOP); writes to reg7 are ignored.
REQ-015 Each channel SHALL hold a 24-bit position POS (16.8 fixed point); ROM_ADDR is POS[23:8].
REQ-016 Sequencer SHALL serve channels round-robin 0..NCH-1 and wrap to 0; each slot is exactly ROM_WAIT+3 cycles whatever the channel state.
REQ-017 Slot states:
- S_ADDR: ROM_ADDR = channel POS[23:8], ROM_nOE=1.
- S_READ: ROM_nOE=0 for ROM_WAIT cycles, ROM_ADDR held.
- S_LATCH: ROM_DATA captured, ROM_nOE=0.
- S_UPDATE: ROM_nOE=1, POS advanced, end check; next state is S_ADDR of the next channel.
REQ-018 For a channel with EN=0, ROM_nOE SHALL stay 1 for the whole slot, no SAMPLE_VALID is issued, and POS is unchanged.
REQ-019 For a channel with EN=1, the cycle after S_LATCH SHALL drive SAMPLE=captured byte, SAMPLE_CH=channel and SAMPLE_VALID=1 for exactly one cycle; SAMPLE/SAMPLE_CH hold between pulses.
REQ-020 In S_UPDATE, POS SHALL be set to (POS + {12'b0, STEP, 4'b0}) mod 2^24; wrap past 0xFFFFFF is silent.
REQ-021 End check on the new POS: if new POS[23:16] == END_HI, then POS = {LOOP_HI, LOOP_LO, 8'h00} when LOOP=1; otherwise EN is cleared and POS is unchanged.
REQ-022 STEP=0 SHALL re-fetch the same byte every slot, with no error.
REQ-023 A CPU write SHALL take effect at the next clock edge.
REQ-024 A CPU write to CTRL that changes EN from 0 to 1 SHALL load POS = {START_HI, START_LO, 8'h00}.
REQ-025 Writes to START/LOOP/END/STEP SHALL NOT alter POS.
REQ-026 If a CPU CTRL write hits the channel's S_UPDATE cycle, the CPU write SHALL win for EN and POS; the sequencer's advance is discarded.
REQ-027 A CPU write mid-slot to the channel being fetched SHALL NOT alter ROM_ADDR until that channel's next S_ADDR.

Reset
REQ-028 RESET=1 at a clock edge SHALL clear all channel registers and POS to 0, so every EN=0.
REQ-029 RESET SHALL force the sequencer to S_ADDR of channel 0 and drive ROM_ADDR=0, ROM_nOE=1, SAMPLE=0, SAMPLE_CH=0 and SAMPLE_VALID=0.
REQ-030 RESET asserted mid-slot SHALL abort the fetch with no SAMPLE_VALID pulse, and RESET SHALL take priority over CPU_WE.

Verification
REQ-031 Reset, no writes, with NCH=8 and ROM_WAIT=1 -> ROM_nOE held 1 and SAMPLE_VALID never asserts for 200 cycles.
REQ-032 Channel 2: START=0x1000, STEP=0x10, END_HI=0xFF, EN=1; ROM[0x1000..0x1002]=0xA0,0xA1,0xA2 -> SAMPLE_CH=2 and SAMPLE=0xA0, then 0xA1, then 0xA2, with pulses 32 cycles apart (8 slots x 4 cycles).
REQ-033 Channel 0: START=0x12FE, STEP=0x10, END_HI=0x13, LOOP=1, LOOP=0x1200 -> ROM_ADDR sequence 0x12FE, 0x12FF, 0x1200, 0x1201.
REQ-034 Same as REQ-033 with LOOP=0 -> two samples, then CTRL bit0 reads as cleared and ROM_nOE stays high in channel 0 slots.
REQ-035 STEP=0x08 -> each ROM address is fetched twice in successive slots of that channel.
REQ-036 RESET during S_READ of channel 3 -> no SAMPLE_VALID, all outputs take their reset values at the next edge, and the sequencer restarts at channel 0.
